// File: rtl/bitstream_fetch.sv
// Streams SRAM words into a 64-bit bit buffer and exposes the oldest 16 bits for a parser.
// Define BITSTREAM_FETCH_HEADER_CHECK_EN to require a 32'hDEADBEEF header before the payload.
module bitstream_fetch #(
  parameter int unsigned SRAM_LATENCY = 2
) (
  input  logic        CLOCK_50_I,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [17:0] base_address,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic [15:0] peek_bits,
  output logic        bits_valid,
  input  logic        shift_en,
  input  logic [4:0]  shift_amt,
  output logic        busy,
`ifdef BITSTREAM_FETCH_HEADER_CHECK_EN
  output logic        header_error,
`endif
  output logic        underrun_error
);

`ifdef BITSTREAM_FETCH_HEADER_CHECK_EN
  typedef enum logic [2:0] {StIdle, StFill, StRun, StDrain, StHdr, StError} state_e;
`else
  typedef enum logic [1:0] {StIdle, StFill, StRun, StDrain} state_e;
`endif

  state_e                  state_q, state_d;
  logic [17:0]             ptr_q, ptr_d;
  logic [17:0]             addr_q, addr_d;
  logic [63:0]             buf_q, buf_d;
  logic [6:0]              count_q, count_d;
  logic [SRAM_LATENCY-1:0] pipe_q, pipe_d;
  logic                    underrun_q, underrun_d;
`ifdef BITSTREAM_FETCH_HEADER_CHECK_EN
  logic                    hdr_err_q, hdr_err_d;
  logic                    hdr_match, hdr_bad;
`endif

  logic        fetching, issue, arrive, accept_shift, bad_shift;
  logic [9:0]  inflight, level;
  logic [6:0]  consume, kept;
  logic [63:0] shifted;

  always_comb begin
    fetching = (state_q == StFill) || (state_q == StRun);
`ifdef BITSTREAM_FETCH_HEADER_CHECK_EN
    fetching = fetching || (state_q == StHdr);
`endif
    inflight = '0;
    for (int i = 0; i < SRAM_LATENCY; i++) begin
      inflight = inflight + 10'(pipe_q[i]);
    end
    // Reserve buffer room for every read still in flight before issuing another.
    level        = 10'(count_q) + (inflight << 4);
    issue        = fetching && !stop && (level <= 10'd48);
    arrive       = pipe_q[SRAM_LATENCY-1];
    bits_valid   = (state_q == StRun) && (count_q >= 7'd16);
    accept_shift = shift_en && bits_valid && (shift_amt <= 5'd16);
    bad_shift    = shift_en && (shift_amt != 5'd0) && !accept_shift;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    buf_d      = buf_q;
    count_d    = count_q;
    underrun_d = underrun_q | bad_shift;
    consume    = accept_shift ? 7'(shift_amt) : 7'd0;
`ifdef BITSTREAM_FETCH_HEADER_CHECK_EN
    hdr_err_d  = hdr_err_q;
    hdr_match  = (state_q == StHdr) && (count_q >= 7'd32) && (buf_q[63:32] == 32'hDEADBEEF);
    hdr_bad    = (state_q == StHdr) &&
                 (((count_q >= 7'd16) && (buf_q[63:48] != 16'hDEAD)) ||
                  ((count_q >= 7'd32) && (buf_q[63:32] != 32'hDEADBEEF)));
    if (hdr_match) begin
      consume = 7'd32;
    end
`endif
    shifted = buf_q << consume;
    kept    = count_q - consume;

    if (fetching) begin
      buf_d   = shifted;
      count_d = kept;
      if (arrive) begin
        // New word lands directly below the newest retained bit.
        buf_d   = shifted | ({SRAM_read_data, 48'd0} >> kept);
        count_d = kept + 7'd16;
      end
    end

    if (issue) begin
      addr_d = ptr_q;
      ptr_d  = ptr_q + 18'd1;
    end

    pipe_d[0] = issue;
    for (int i = 1; i < SRAM_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          ptr_d   = base_address;
          count_d = '0;
          buf_d   = '0;
`ifdef BITSTREAM_FETCH_HEADER_CHECK_EN
          hdr_err_d = 1'b0;
          state_d   = StHdr;
`else
          state_d   = StFill;
`endif
        end
      end
      StFill: if (count_d >= 7'd16) state_d = StRun;
      StRun:  if (count_d < 7'd16) state_d = StFill;
      StDrain: if (pipe_q == '0) state_d = StIdle;
`ifdef BITSTREAM_FETCH_HEADER_CHECK_EN
      StHdr: begin
        if (hdr_match) begin
          state_d = StFill;
        end else if (hdr_bad) begin
          state_d   = StError;
          hdr_err_d = 1'b1;
        end
      end
      StError: state_d = StError;
`endif
      default: state_d = StIdle;
    endcase

    if (stop && (state_q != StIdle) && (state_q != StDrain)) begin
      state_d = StDrain;
      count_d = '0;
      buf_d   = '0;
    end
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      addr_q     <= '0;
      buf_q      <= '0;
      count_q    <= '0;
      pipe_q     <= '0;
      underrun_q <= 1'b0;
`ifdef BITSTREAM_FETCH_HEADER_CHECK_EN
      hdr_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      count_q    <= count_d;
      pipe_q     <= pipe_d;
      underrun_q <= underrun_d;
`ifdef BITSTREAM_FETCH_HEADER_CHECK_EN
      hdr_err_q  <= hdr_err_d;
`endif
    end
  end

  // The issuing address goes out in the same cycle the read is counted.
  assign SRAM_address   = issue ? ptr_q : addr_q;
  assign SRAM_we_n      = 1'b1;
  assign peek_bits      = buf_q[63:48];
  assign busy           = (state_q != StIdle);
  assign underrun_error = underrun_q;
`ifdef BITSTREAM_FETCH_HEADER_CHECK_EN
  assign header_error   = hdr_err_q;
`endif

endmodule

// File: doc/bitstream_fetch.md
BITSTREAM_FETCH -- requirements
Module: bitstream_fetch

Interface
REQ-001 Parameter SRAM_LATENCY, default 2: clock cycles from SRAM_address driven to matching SRAM_read_data valid.
REQ-002 CLOCK_50_I  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  single-cycle pulse; latches base_address and begins fetching.
REQ-005 stop  input  1  single-cycle pulse; halts fetching and discards buffered bits.
REQ-006 base_address  input  18  SRAM word address of first bitstream word.
REQ-007 SRAM_address  output  18  read address to SRAM controller.
REQ-008 SRAM_we_n  output  1  tied high; block never writes.
REQ-009 SRAM_read_data  input  16  SRAM read word.
REQ-010 peek_bits  output  16  next 16 unconsumed bits, MSB = oldest bit.
REQ-011 bits_valid  output  1  high when buffer holds >=16 bits and state is RUN.
REQ-012 shift_en  input  1  consume shift_amt bits this cycle.
REQ-013 shift_amt  input  5  bits to consume, 0..16.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 underrun_error  output  1  sticky; set on illegal shift request.

Function
REQ-016 States: IDLE, FILL, RUN, DRAIN (plus HDR and ERROR when macro defined, REQ-031).
REQ-017 IDLE->FILL on start; address pointer := base_address; bit count := 0.
REQ-018 Bit buffer 64 bits; word issued only when count + 16*(in-flight reads) <= 48.
REQ-019 At most one read issued per cycle; pointer increments after each issue, wrapping 18'h3FFFF -> 0.
REQ-020 In-flight tracking via SRAM_LATENCY-deep valid shift pipe; returned word appended below newest bit.
REQ-021 FILL->RUN when count >= 16; bits_valid rises the same cycle state is RUN.
REQ-022 shift_en with bits_valid high and shift_amt <= 16: count -= shift_amt; peek_bits reflects it next cycle.
REQ-023 Simultaneous word arrival and shift in one cycle: count := count - shift_amt + 16, no data lost.
REQ-024 shift_en with bits_valid low, or shift_amt > 16: request ignored, underrun_error := 1.
REQ-025 shift_amt = 0 with shift_en: no change, no error.
REQ-026 RUN->FILL if count drops below 16; fetching continues.
REQ-027 stop in FILL/RUN: stop issuing, count := 0, go DRAIN; DRAIN->IDLE once in-flight reads = 0; returning words discarded.
REQ-028 start while busy ignored; stop in IDLE ignored; start and stop same cycle: stop wins.
REQ-029 SRAM_address holds last issued value when not issuing.

Reset
REQ-030 On reset: state IDLE, SRAM_address 0, SRAM_we_n 1, peek_bits 0, bits_valid 0, busy 0, underrun_error 0, count 0, in-flight pipe cleared; reset mid-operation discards all pending returns.

Configuration
REQ-031 Macro BITSTREAM_FETCH_HEADER_CHECK_EN defined: FILL preceded by HDR; first 32 bits compared to 32'hDEADBEEF; match -> bits discarded, FILL continues; mismatch -> ERROR, fetching stops, output header_error  output  1 set.
REQ-032 ERROR exits only on reset or stop (via DRAIN); header_error cleared on reset or start.
REQ-033 Macro undefined: no HDR/ERROR states, no header_error port; first bit of base_address word is first peek bit.

Verification
REQ-034 SRAM model words 16'h1234,16'h5678 at base 18'h100, start -> bits_valid high, peek_bits=16'h1234; shift 4 -> 16'h2345.
REQ-035 Continuous shift_amt=16 every cycle with bits_valid -> consumed stream equals memory content word-for-word, no gaps beyond fill.
REQ-036 base_address 18'h3FFFF -> second read address 18'h00000.
REQ-037 shift_en in FILL (bits_valid=0) -> underrun_error=1, peek_bits/count unchanged.
REQ-038 stop with 2 reads in flight -> busy stays high until both return, then IDLE; new start at 18'h200 -> peek_bits = word at 18'h200.
REQ-039 Macro defined: first words 16'hDEAD,16'hBEEF,16'hABCD -> peek_bits=16'hABCD; first word 16'hDEAF -> header_error=1, no further reads.
